// File: rtl/sync_frame_controller.sv
// Serial frame synchronizer: hunts for a sync header, locks after LOCK_CNT good
// headers, then alternates payload capture and header checks. Isolated header
// errors are ridden through; MISS_CNT consecutive misses drop lock.
module sync_frame_controller #(
  parameter int unsigned       SYNC_W       = 6,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 6'b110011,
  parameter int unsigned       PAYLOAD_W    = 8,
  parameter int unsigned       LOCK_CNT     = 2,
  parameter int unsigned       MISS_CNT     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 a,
  output logic                 frame_valid,
  output logic [PAYLOAD_W-1:0] frame_data,
  output logic                 locked,
  output logic                 sync_error
);

  localparam int unsigned BitMax = (PAYLOAD_W > SYNC_W) ? PAYLOAD_W : SYNC_W;
  localparam int unsigned BitW   = $clog2(BitMax + 1);
  localparam int unsigned FillW  = $clog2(SYNC_W + 1);
  localparam int unsigned GoodW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW  = $clog2(MISS_CNT + 1);

  localparam logic [FillW-1:0] FillMax  = FillW'(SYNC_W);
  localparam logic [BitW-1:0]  PayLast  = BitW'(PAYLOAD_W - 1);
  localparam logic [BitW-1:0]  SyncLast = BitW'(SYNC_W - 1);
  localparam logic [GoodW-1:0] GoodMax  = GoodW'(LOCK_CNT);
  localparam logic [MissW-1:0] MissMax  = MissW'(MISS_CNT);

  typedef enum logic [1:0] {StHunt, StPayload, StCheck} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_W-1:0]      window_q, window_d;
  logic [SYNC_W-1:0]      cmp_q, cmp_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [PAYLOAD_W-1:0]   frame_data_q, frame_data_d;
  logic [FillW-1:0]       fill_q, fill_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [GoodW-1:0]       good_q, good_d;
  logic [MissW-1:0]       miss_q, miss_d;
  logic                   locked_q, locked_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   sync_error_q, sync_error_d;

  // Next-state logic; everything holds unless a bit is accepted.
  always_comb begin
    state_d       = state_q;
    window_d      = window_q;
    cmp_d         = cmp_q;
    payload_d     = payload_q;
    frame_data_d  = frame_data_q;
    fill_d        = fill_q;
    bit_cnt_d     = bit_cnt_q;
    good_d        = good_q;
    miss_d        = miss_q;
    locked_d      = locked_q;
    frame_valid_d = 1'b0;
    sync_error_d  = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        StHunt: begin
          window_d = {window_q[SYNC_W-2:0], a};
          if (fill_q != FillMax) fill_d = fill_q + 1'b1;
          // Sliding compare every bit, so overlapping headers are not skipped.
          if (window_d == SYNC_PATTERN && fill_q >= FillMax - 1'b1) begin
            good_d    = GoodW'(1);
            bit_cnt_d = '0;
            state_d   = StPayload;
            if (GoodMax == GoodW'(1)) locked_d = 1'b1;
          end
        end
        StPayload: begin
          payload_d = {payload_q[PAYLOAD_W-2:0], a};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == PayLast) begin
            // Words captured before lock are dropped.
            if (locked_q) begin
              frame_data_d  = payload_d;
              frame_valid_d = 1'b1;
            end
            bit_cnt_d = '0;
            state_d   = StCheck;
          end
        end
        StCheck: begin
          cmp_d     = {cmp_q[SYNC_W-2:0], a};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == SyncLast) begin
            bit_cnt_d = '0;
            if (cmp_d == SYNC_PATTERN) begin
              if (good_q != GoodMax) good_d = good_q + 1'b1;
              miss_d  = '0;
              if (good_d == GoodMax) locked_d = 1'b1;
              state_d = StPayload;
            end else if (!locked_q) begin
              sync_error_d = 1'b1;
              good_d       = '0;
              fill_d       = '0;
              window_d     = '0;
              state_d      = StHunt;
            end else begin
              sync_error_d = 1'b1;
              if (miss_q == MissMax - 1'b1) begin
                locked_d = 1'b0;
                miss_d   = '0;
                good_d   = '0;
                fill_d   = '0;
                state_d  = StHunt;
              end else begin
                // Flywheel: keep framing through an isolated bad header.
                miss_d  = miss_q + 1'b1;
                good_d  = GoodMax;
                state_d = StPayload;
              end
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHunt;
      window_q      <= '0;
      cmp_q         <= '0;
      payload_q     <= '0;
      frame_data_q  <= '0;
      fill_q        <= '0;
      bit_cnt_q     <= '0;
      good_q        <= '0;
      miss_q        <= '0;
      locked_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      window_q      <= window_d;
      cmp_q         <= cmp_d;
      payload_q     <= payload_d;
      frame_data_q  <= frame_data_d;
      fill_q        <= fill_d;
      bit_cnt_q     <= bit_cnt_d;
      good_q        <= good_d;
      miss_q        <= miss_d;
      locked_q      <= locked_d;
      frame_valid_q <= frame_valid_d;
      sync_error_q  <= sync_error_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign locked      = locked_q;
  assign sync_error  = sync_error_q;

endmodule

// File: doc/sync_frame_controller.md
Name: sync_frame_controller

Overview:
Frame synchronizer for the serial bit stream `a`. It hunts for a programmable sync header and acquires lock after consecutive good headers. Once aligned, it sequences alternating payload-capture and header-check phases and delivers parallel payload words. It tolerates isolated header errors ("flywheel") and drops lock after repeated misses. It sits after the serial input and feeds word-level consumers.

Parameters:
SYNC_W, 6, sync header length in bits (2..16)
SYNC_PATTERN, 6'b110011, sync header value; first-received bit is the MSB
PAYLOAD_W, 8, payload bits per frame; shifted in MSB first
LOCK_CNT, 2, consecutive good headers needed to assert locked (>=1)
MISS_CNT, 3, consecutive bad headers while locked that drop lock (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
bit_valid  input  1  `a` is sampled only when high
a  input  1  serial data bit
frame_valid  output  1  one-cycle pulse: frame_data holds a payload word
frame_data  output  PAYLOAD_W  last delivered payload; holds value between pulses
locked  output  1  frame alignment established
sync_error  output  1  one-cycle pulse on each header mismatch detected in CHECK

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- All state advances only on cycles with bit_valid=1 ("accepted bit"). With bit_valid=0, state, counters and window hold, and pulses are 0.
- Reset values:
  - outputs: frame_valid=0, frame_data=0, locked=0, sync_error=0
  - internal: state=HUNT, window=0, fill=0, bit_cnt=0, good_cnt=0, miss_cnt=0
- A reset in any state, including mid-payload, takes effect at the next edge. No partial frame is emitted.
- States are HUNT, PAYLOAD and CHECK.
- HUNT:
  - window <= {window[SYNC_W-2:0], a}.
  - fill increments and saturates at SYNC_W.
  - Match condition: the new window value equals SYNC_PATTERN and (fill+1) >= SYNC_W. Overlapping occurrences are found; there is no bit skipping.
  - On match: good_cnt=1, bit_cnt=0, go to PAYLOAD. If LOCK_CNT==1, locked=1 in the same edge.
- PAYLOAD:
  - Shift `a` into the payload register; bit_cnt increments.
  - On the PAYLOAD_W-th bit: if locked is 1 at that edge, frame_data <= completed word and frame_valid=1 in the next cycle. If locked is 0, the word is discarded.
  - Then bit_cnt=0 and go to CHECK.
- CHECK:
  - Shift SYNC_W bits into a compare register.
  - Match on the SYNC_W-th bit:
    - good_cnt++ (saturates at LOCK_CNT) and miss_cnt=0.
    - If good_cnt reaches LOCK_CNT, set locked=1; it is visible in the cycle after that edge.
    - Go to PAYLOAD.
  - Mismatch, not locked: sync_error pulse, good_cnt=0, go to HUNT with fill=0 and window=0.
  - Mismatch, locked:
    - sync_error pulse, miss_cnt++ and good_cnt=LOCK_CNT.
    - If miss_cnt reaches MISS_CNT: locked=0, miss_cnt=0, good_cnt=0, go to HUNT with fill=0.
    - Otherwise (flywheel): go to PAYLOAD and keep frame delivery.
- A lock drop and a payload completion never coincide, because they occur in different states.
- Counter widths are $clog2(max+1). None of the counters wrap.

Test Plan:
- Reset: hold rst 3 cycles with random `a` -> all outputs 0. Release: no frame_valid for the first 6 bits of any input.
- Acquisition (SYNC 110011, PAYLOAD_W=8): stream 110011, A5, 110011, 3C, 110011 with bit_valid=1.
  - The A5 word is discarded.
  - locked rises the cycle after the 2nd header's last bit.
  - frame_valid pulses exactly once, with frame_data=8'h3C.
- Overlap: prefix 1101 then 110011, 5A, 110011, C3 -> header found at the correct offset and frame_data=8'hC3.
- Flywheel and loss, while locked:
  - One header corrupted to 110010: sync_error pulses once, locked stays 1, and the next payload is delivered.
  - Three consecutive corrupted headers: locked falls after the 3rd, state returns to HUNT, and no further frame_valid appears until re-lock.
- Gaps: repeat the acquisition stream with bit_valid deasserted for 1..4 random cycles between bits -> identical frame_data/locked sequence; pulses only follow accepted bits.
- Mid-operation reset: assert rst after 4 payload bits while locked -> next cycle locked=0 and frame_valid=0. Re-acquisition then requires LOCK_CNT fresh headers.
